carfield_domain_rst_seq: RTL and testbench

Parametrised per-domain reset/isolation sequencer for the Carfield reset domains (periphery, safety, security, integer cluster, FP cluster, L2 by default). It turns a software reset request or domain-enable change into an ordered sequence per domain:
- isolate the domain's AXI ports and wait for the acknowledge;
- hold the domain in reset;
- release reset and de-isolate.

Disabled domains are parked with their clock gated. It sits between the Carfield control registers and each domain's reset, clock-gate and AXI-isolate cells.

---
 rtl/carfield_domain_rst_seq.sv | 154 +++++++++++++++
 tb/tb_carfield_domain_rst_seq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/carfield_domain_rst_seq.sv
// carfield_domain_rst_seq: per-domain reset / AXI-isolation sequencer.
// Ports: clk_i, rst_i (sync, active-high); per-domain dom_en_i,
//   rst_req_i, isolated_i, err_clr_i in; dom_rst_o, dom_iso_o,
//   dom_clk_en_o, busy_o, done_o, err_o out.
module carfield_domain_rst_seq #(
  parameter int unsigned NumDomains = 6,
  parameter int unsigned RstCycles  = 16,
  parameter int unsigned IsoTimeout = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NumDomains-1:0] dom_en_i,
  input  logic [NumDomains-1:0] rst_req_i,
  input  logic [NumDomains-1:0] isolated_i,
  input  logic [NumDomains-1:0] err_clr_i,
  output logic [NumDomains-1:0] dom_rst_o,
  output logic [NumDomains-1:0] dom_iso_o,
  output logic [NumDomains-1:0] dom_clk_en_o,
  output logic [NumDomains-1:0] busy_o,
  output logic [NumDomains-1:0] done_o,
  output logic [NumDomains-1:0] err_o
);

  localparam int unsigned CntMax =
    (RstCycles > IsoTimeout) ? RstCycles : IsoTimeout;
  localparam int unsigned CntWidth = $clog2(CntMax + 1);

  localparam logic [CntWidth-1:0] RstLast =
    CntWidth'(RstCycles - 1);
  localparam logic [CntWidth-1:0] IsoLast =
    CntWidth'(IsoTimeout - 1);
  localparam bit IsoTmoEn = (IsoTimeout != 0);

  typedef enum logic [2:0] {
    S_RESET,
    S_DEISO,
    S_ACTIVE,
    S_ISO,
    S_OFF
  } state_t;

  for (genvar d = 0; d < NumDomains; d++) begin : g_dom
    state_t              r_state;
    state_t              w_next;
    logic [CntWidth-1:0] r_cnt;
    logic                r_err;
    logic                r_done;
    logic                w_tmo;
    logic                w_cnt_clr;
    logic                w_rst;
    logic                w_iso;
    logic                w_clk_en;
    logic                w_busy;

    always_comb begin
      w_next = r_state;
      w_tmo  = 1'b0;
      unique case (r_state)
        S_RESET: begin
          if (r_cnt == RstLast)
            w_next = dom_en_i[d] ? S_DEISO : S_OFF;
        end
        S_DEISO: begin
          if (!isolated_i[d]) begin
            w_next = S_ACTIVE;
          end else if (IsoTmoEn && r_cnt == IsoLast) begin
            w_next = S_ACTIVE;
            w_tmo  = 1'b1;
          end
        end
        S_ACTIVE: begin
          if (!dom_en_i[d] || rst_req_i[d])
            w_next = S_ISO;
        end
        S_ISO: begin
          if (isolated_i[d]) begin
            w_next = S_RESET;
          end else if (IsoTmoEn && r_cnt == IsoLast) begin
            w_next = S_RESET;
            w_tmo  = 1'b1;
          end
        end
        S_OFF: begin
          if (dom_en_i[d])
            w_next = S_RESET;
        end
        default: w_next = S_RESET;
      endcase
    end

    // counter restarts on every state change and idles in ACTIVE/OFF
    assign w_cnt_clr = (w_next != r_state) ||
                       (r_state == S_ACTIVE) ||
                       (r_state == S_OFF);

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_state <= S_RESET;
        r_cnt   <= '0;
        r_err   <= 1'b0;
        r_done  <= 1'b0;
      end else begin
        r_state <= w_next;
        r_cnt   <= w_cnt_clr ? '0 : r_cnt + CntWidth'(1);
        // a timeout in the same cycle as a clear keeps the flag
        r_err   <= w_tmo | (r_err & ~err_clr_i[d]);
        r_done  <= (w_next == S_ACTIVE) &&
                   (r_state != S_ACTIVE);
      end
    end

    always_comb begin
      w_rst    = 1'b1;
      w_iso    = 1'b1;
      w_clk_en = 1'b1;
      w_busy   = 1'b1;
      unique case (r_state)
        S_RESET: begin
          w_rst    = 1'b1;
          w_iso    = 1'b1;
        end
        S_DEISO: begin
          w_rst    = 1'b0;
          w_iso    = 1'b0;
        end
        S_ACTIVE: begin
          w_rst    = 1'b0;
          w_iso    = 1'b0;
          w_busy   = 1'b0;
        end
        S_ISO: begin
          w_rst    = 1'b0;
          w_iso    = 1'b1;
        end
        S_OFF: begin
          w_clk_en = 1'b0;
          w_busy   = 1'b0;
        end
        default: begin
          w_rst    = 1'b1;
          w_iso    = 1'b1;
        end
      endcase
    end

    assign dom_rst_o[d]    = w_rst;
    assign dom_iso_o[d]    = w_iso;
    assign dom_clk_en_o[d] = w_clk_en;
    assign busy_o[d]       = w_busy;
    assign done_o[d]       = r_done;
    assign err_o[d]        = r_err;
  end

endmodule

// File: tb/tb_carfield_domain_rst_seq.sv
// tb_carfield_domain_rst_seq: directed bench for the domain sequencer.
// Ack model: isolated_i mirrors dom_iso_o one cycle late unless forced.
module tb_carfield_domain_rst_seq;

  localparam int ND = 6;
  localparam logic [ND-1:0] ALL = '1;

  logic          clk;
  logic          rst_i;
  logic [ND-1:0] dom_en_i;
  logic [ND-1:0] rst_req_i;
  logic [ND-1:0] isolated_i;
  logic [ND-1:0] err_clr_i;
  logic [ND-1:0] dom_rst_o;
  logic [ND-1:0] dom_iso_o;
  logic [ND-1:0] dom_clk_en_o;
  logic [ND-1:0] busy_o;
  logic [ND-1:0] done_o;
  logic [ND-1:0] err_o;

  logic [ND-1:0] frc_en;
  logic [ND-1:0] frc_val;
  logic [ND-1:0] iso_cap;

  int n_chk;
  int n_fail;

  carfield_domain_rst_seq dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .dom_en_i     (dom_en_i),
    .rst_req_i    (rst_req_i),
    .isolated_i   (isolated_i),
    .err_clr_i    (err_clr_i),
    .dom_rst_o    (dom_rst_o),
    .dom_iso_o    (dom_iso_o),
    .dom_clk_en_o (dom_clk_en_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    isolated_i = '1;
    iso_cap    = '1;
    forever begin
      @(negedge clk);
      iso_cap = dom_iso_o;
      @(posedge clk);
      #2;
      isolated_i = (frc_en & frc_val) | (~frc_en & iso_cap);
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to_done(input int d,
                             output int n_rst, output int n_iso,
                             output int n_deiso, output int n_cyc,
                             output int n_oth);
    logic [ND-1:0] om;
    om = ~(ND'(1) << d);
    n_rst = 0; n_iso = 0; n_deiso = 0; n_cyc = 0; n_oth = 0;
    while (!done_o[d] && n_cyc < 600) begin
      if (dom_rst_o[d] && dom_clk_en_o[d]) n_rst++;
      if (!dom_rst_o[d] && dom_iso_o[d]) n_iso++;
      if (busy_o[d] && !dom_iso_o[d]) n_deiso++;
      if (((dom_rst_o | dom_iso_o | busy_o | done_o |
            ~dom_clk_en_o) & om) != '0) n_oth++;
      n_cyc++;
      tick();
    end
  endtask

  task automatic chk_rst_vals(input string tag);
    chk({tag, "_rst"}, dom_rst_o, ALL);
    chk({tag, "_iso"}, dom_iso_o, ALL);
    chk({tag, "_clk"}, dom_clk_en_o, ALL);
    chk({tag, "_busy"}, busy_o, ALL);
    chk({tag, "_done"}, done_o, '0);
    chk({tag, "_err"}, err_o, '0);
  endtask

  int nr, ni, nd, nc, no;
  int cnt, rc;

  initial begin
    n_chk = 0; n_fail = 0;
    rst_i = 1'b1; dom_en_i = ALL; rst_req_i = '0;
    err_clr_i = '0; frc_en = '0; frc_val = '0;

    // power-on
    repeat (3) tick();
    chk_rst_vals("por");
    rst_i = 1'b0;
    run_to_done(0, nr, ni, nd, nc, no);
    chk("por_rst_cycles", nr, 16);
    chk("por_deiso_cycles", nd, 2);
    chk("por_done_cycle", nc, 18);
    chk("por_done_all", done_o, ALL);
    tick();
    chk("por_done_pulse", done_o, '0);
    chk("por_busy", busy_o, '0);
    chk("por_rst_low", dom_rst_o, '0);
    chk("por_iso_low", dom_iso_o, '0);

    // software reset of domain 3, ack after 5 cycles
    frc_en[3] = 1'b1; frc_val[3] = 1'b0;
    rst_req_i[3] = 1'b1;
    tick();
    rst_req_i[3] = 1'b0;
    chk("req3_iso_rise", dom_iso_o, 6'b001000);
    chk("req3_rst_low", dom_rst_o, '0);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (dom_iso_o[3] && !dom_rst_o[3]) cnt++;
      if (i == 4) frc_val[3] = 1'b1;
      tick();
    end
    chk("req3_iso_cycles", cnt, 5);
    frc_en[3] = 1'b0;
    chk("req3_rst_after_ack", dom_rst_o[3], 1'b1);
    run_to_done(3, nr, ni, nd, nc, no);
    chk("req3_rst_cycles", nr, 16);
    chk("req3_deiso", nd, 2);
    chk("req3_others", no, 0);
    chk("req3_done", done_o, 6'b001000);
    tick();
    chk("req3_done_pulse", done_o, '0);
    chk("req3_busy", busy_o, '0);

    // disable domain 4, then re-enable
    dom_en_i[4] = 1'b0;
    tick();
    cnt = 0; rc = 0;
    while (busy_o[4] && cnt < 100) begin
      if (dom_rst_o[4]) rc++;
      cnt++;
      tick();
    end
    chk("off4_seq_cycles", cnt, 18);
    chk("off4_rst_cycles", rc, 16);
    chk("off4_clk", dom_clk_en_o, 6'b101111);
    chk("off4_rst", dom_rst_o, 6'b010000);
    chk("off4_iso", dom_iso_o, 6'b010000);
    repeat (5) tick();
    chk("off4_parked", dom_clk_en_o[4], 1'b0);
    chk("off4_no_done", done_o, '0);
    dom_en_i[4] = 1'b1;
    tick();
    chk("on4_rst", dom_rst_o[4], 1'b1);
    run_to_done(4, nr, ni, nd, nc, no);
    chk("on4_rst_clk_on", nr, 16);
    chk("on4_done_cycle", nc, 18);
    chk("on4_others", no, 0);
    tick();

    // stuck ack on domain 1
    frc_en[1] = 1'b1; frc_val[1] = 1'b0;
    rst_req_i[1] = 1'b1;
    tick();
    rst_req_i[1] = 1'b0;
    cnt = 0;
    while (dom_iso_o[1] && !dom_rst_o[1] && cnt < 400) begin
      cnt++;
      tick();
    end
    chk("tmo1_iso_cycles", cnt, 256);
    chk("tmo1_err", err_o, 6'b000010);
    chk("tmo1_reset", dom_rst_o[1], 1'b1);
    run_to_done(1, nr, ni, nd, nc, no);
    chk("tmo1_rst_cycles", nr, 16);
    chk("tmo1_deiso", nd, 1);
    err_clr_i[1] = 1'b1;
    tick();
    err_clr_i[1] = 1'b0;
    chk("tmo1_clr", err_o, '0);
    rst_req_i[1] = 1'b1;
    tick();
    rst_req_i[1] = 1'b0;
    repeat (254) tick();
    chk("tmo2_pre_err", err_o, '0);
    chk("tmo2_still_iso", dom_iso_o[1], 1'b1);
    tick();
    err_clr_i[1] = 1'b1;
    tick();
    err_clr_i[1] = 1'b0;
    chk("tmo2_set_wins", err_o, 6'b000010);
    chk("tmo2_reset", dom_rst_o[1], 1'b1);
    run_to_done(1, nr, ni, nd, nc, no);
    chk("tmo2_done", done_o, 6'b000010);
    frc_en[1] = 1'b0;
    tick();

    // reset mid-ISO (domain 2) and mid-RESET (domain 5)
    frc_en[2] = 1'b1; frc_val[2] = 1'b0;
    rst_req_i = 6'b100100;
    tick();
    rst_req_i = '0;
    repeat (9) tick();
    chk("mid_rst", dom_rst_o, 6'b100000);
    chk("mid_iso", dom_iso_o, 6'b100100);
    chk("mid_err", err_o, 6'b000010);
    frc_en = '0;
    rst_i = 1'b1;
    tick();
    chk_rst_vals("mid");
    rst_i = 1'b0;
    run_to_done(2, nr, ni, nd, nc, no);
    chk("mid_rst_cycles", nr, 16);
    chk("mid_done_cycle", nc, 18);
    chk("mid_done_all", done_o, ALL);
    tick();

    // requests during RESET/DEISO are dropped
    rst_req_i[0] = 1'b1;
    tick();
    rst_req_i[0] = 1'b0;
    cnt = 0;
    while (!done_o[0] && cnt < 100) begin
      rst_req_i[0] = busy_o[0] &&
                     (dom_rst_o[0] || !dom_iso_o[0]);
      cnt++;
      tick();
    end
    rst_req_i[0] = 1'b0;
    chk("ign_seq_cycles", cnt, 20);
    rc = 0;
    repeat (20) begin
      if (busy_o[0]) rc++;
      tick();
    end
    chk("ign_no_second", rc, 0);
    chk("ign_active", dom_iso_o, '0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
